// File: rtl/state3.sv
// Four-state A-sequencer (IDLE/START/STOP/CLEAR) with registered K1/K2 flags.
// Define STATE3_SYNC_IN_EN to add a two-flop synchronizer on A (2 cycles of latency).
module state3 #(
  parameter int unsigned ONE_HOT = 0
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic A,
  output logic K1,
  output logic K2
);

  localparam int unsigned SW = (ONE_HOT != 0) ? 4 : 2;

  typedef enum logic [SW-1:0] {
    IDLE  = SW'((ONE_HOT != 0) ? 1 : 0),
    START = SW'((ONE_HOT != 0) ? 2 : 1),
    STOP  = SW'((ONE_HOT != 0) ? 4 : 2),
    CLEAR = SW'((ONE_HOT != 0) ? 8 : 3)
  } state_e;

  state_e state_q;
  state_e state_d;
  logic   k1_q, k1_d;
  logic   k2_q, k2_d;
  logic   a_s;

`ifdef STATE3_SYNC_IN_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer; the FSM sees A two edges late.
  always_ff @(posedge clk_i) begin
    if (rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], A};
    end
  end

  assign a_s = sync_q[1];
`else
  assign a_s = A;
`endif

  // State and flag registers; reset (active-high) overrides any transition.
  always_ff @(posedge clk_i) begin
    if (rst_n) begin
      state_q <= IDLE;
      k1_q    <= 1'b0;
      k2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k1_q    <= k1_d;
      k2_q    <= k2_d;
    end
  end

  // Next state and flag updates; an unknown A falls to the default arm and holds.
  always_comb begin
    state_d = state_q;
    k1_d    = k1_q;
    k2_d    = k2_q;
    case (state_q)
      IDLE: begin
        case (a_s)
          1'b1: begin
            state_d = START;
            k1_d    = 1'b0;
          end
          1'b0:    state_d = IDLE;
          default: state_d = state_q;
        endcase
      end
      START: begin
        case (a_s)
          1'b0:    state_d = STOP;
          1'b1:    state_d = START;
          default: state_d = state_q;
        endcase
      end
      STOP: begin
        case (a_s)
          1'b1: begin
            state_d = CLEAR;
            k2_d    = 1'b1;
          end
          1'b0:    state_d = STOP;
          default: state_d = state_q;
        endcase
      end
      CLEAR: begin
        case (a_s)
          1'b0: begin
            state_d = IDLE;
            k1_d    = 1'b1;
            k2_d    = 1'b0;
          end
          1'b1:    state_d = CLEAR;
          default: state_d = state_q;
        endcase
      end
      default: begin
        // Non-one-hot codes recover to IDLE with both flags cleared.
        state_d = IDLE;
        k1_d    = 1'b0;
        k2_d    = 1'b0;
      end
    endcase
  end

  assign K1 = k1_q;
  assign K2 = k2_q;

endmodule

// File: tb/tb_state3.sv
// Directed bench for state3: binary and one-hot instances driven in lockstep.
// Expectations shift by the synchronizer latency when STATE3_SYNC_IN_EN is defined.
module tb_state3;

`ifdef STATE3_SYNC_IN_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  localparam int S_IDLE  = 0;
  localparam int S_START = 1;
  localparam int S_STOP  = 2;
  localparam int S_CLEAR = 3;

  logic clk_i = 1'b0;
  logic rst_n = 1'b1;
  logic A     = 1'b0;
  logic k1_b, k2_b, k1_h, k2_h;

  int total = 0;
  int bad   = 0;

  int a_q[$];
  int st_q[$];
  int k1_q[$];
  int k2_q[$];

  state3 #(.ONE_HOT(0)) dut_bin (.clk_i(clk_i), .rst_n(rst_n), .A(A), .K1(k1_b), .K2(k2_b));
  state3 #(.ONE_HOT(1)) dut_oh  (.clk_i(clk_i), .rst_n(rst_n), .A(A), .K1(k1_h), .K2(k2_h));

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Compare both instances against one expected state index and flag pair.
  task automatic check_all(input string tag, input int st, input int k1, input int k2);
    check({tag, " bin.state"}, int'(dut_bin.state_q), st);
    check({tag, " oh.state"},  int'(dut_oh.state_q), 1 << st);
    check({tag, " bin.K1"}, int'(k1_b), k1);
    check({tag, " bin.K2"}, int'(k2_b), k2);
    check({tag, " oh.K1"},  int'(k1_h), k1);
    check({tag, " oh.K2"},  int'(k2_h), k2);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input int a, input int st, input int k1, input int k2);
    a_q.push_back(a);
    st_q.push_back(st);
    k1_q.push_back(k1);
    k2_q.push_back(k2);
  endtask

  task automatic clear_vec();
    a_q.delete();
    st_q.delete();
    k1_q.delete();
    k2_q.delete();
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
    rst_n = 1'b0;
  endtask

  // Play the queued vectors straight after a reset; step i is checked against vector i-LAT,
  // the last A is repeated LAT more times so the FSM consumes the whole list.
  task automatic run_stream(input string tag);
    int n;
    n = a_q.size();
    for (int i = 0; i < n + LAT; i++) begin
      int j;
      A = (i < n) ? a_q[i][0] : a_q[n-1][0];
      tick();
      j = i - LAT;
      if (j < 0) check_all($sformatf("%s step%0d", tag, i), S_IDLE, 0, 0);
      else       check_all($sformatf("%s step%0d", tag, i), st_q[j], k1_q[j], k2_q[j]);
    end
  endtask

  initial begin
    // Reset held 5 cycles with A=1: IDLE and both flags low throughout.
    A     = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all($sformatf("reset cyc%0d", i), S_IDLE, 0, 0);
    end
    rst_n = 1'b0;

    // Full cycle 1,1,0,0,1,1,0,0 then restart with A=1.
    clear_vec();
    push(1, S_START, 0, 0);
    push(1, S_START, 0, 0);
    push(0, S_STOP,  0, 0);
    push(0, S_STOP,  0, 0);
    push(1, S_CLEAR, 0, 1);
    push(1, S_CLEAR, 0, 1);
    push(0, S_IDLE,  1, 0);
    push(0, S_IDLE,  1, 0);
    push(1, S_START, 0, 0);
    push(1, S_START, 0, 0);
    run_stream("cycle");

    // Hold A=1 for 20 cycles from IDLE, then walk to CLEAR with K2 set.
    do_reset(1);
    clear_vec();
    for (int i = 0; i < 20; i++) push(1, S_START, 0, 0);
    push(0, S_STOP,  0, 0);
    push(1, S_CLEAR, 0, 1);
    push(1, S_CLEAR, 0, 1);
    run_stream("hold");

    // Reset in CLEAR with K2=1: one edge returns to IDLE with flags low.
    rst_n = 1'b1;
    tick();
    check_all("midreset", S_IDLE, 0, 0);
    rst_n = 1'b0;
    A     = 1'b0;
    tick();
    check_all("post-release idle", S_IDLE, 0, 0);

    // A second run after the mid-op reset behaves like a fresh start.
    clear_vec();
    push(1, S_START, 0, 0);
    push(0, S_STOP,  0, 0);
    push(1, S_CLEAR, 0, 1);
    push(0, S_IDLE,  1, 0);
    push(0, S_IDLE,  1, 0);
    do_reset(1);
    run_stream("rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
